// File: rtl/lcd_spi_arbiter.sv
// Two-requester packet arbiter in front of the 9-bit LCD SPI word writer.
// Optional packet statistics are enabled with `define LCD_ARB_STAT_EN.
module lcd_spi_arbiter #(
  parameter logic [15:0] GAP_CYCLES    = 16'd50,
  parameter int          MAX_CMD_BURST = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        cmd_valid,
  input  logic [8:0]  cmd_data,
  input  logic        cmd_last,
  output logic        cmd_ready,
  input  logic        pix_valid,
  input  logic [8:0]  pix_data,
  input  logic        pix_last,
  output logic        pix_ready,
  output logic        wr_valid,
  output logic [8:0]  wr_data,
  input  logic        wr_ready,
  output logic [1:0]  grant,
  output logic        busy
`ifdef LCD_ARB_STAT_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] cmd_pkt_cnt,
  output logic [15:0] pix_pkt_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CMD  = 2'b01;
  localparam logic [1:0] GNT_PIX  = 2'b10;
  localparam logic [3:0] BURST_MAX = 4'(MAX_CMD_BURST);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q;
  logic [15:0] gap_q;
  logic [3:0]  burst_q;

  logic       sel_cmd, sel_valid, sel_last, hs, pick_cmd, pkt_done;
  logic [8:0] sel_data;

  assign sel_cmd   = (grant_q == GNT_CMD);
  assign sel_valid = sel_cmd ? cmd_valid : pix_valid;
  assign sel_data  = sel_cmd ? cmd_data  : pix_data;
  assign sel_last  = sel_cmd ? cmd_last  : pix_last;
  assign hs        = wr_valid & wr_ready;
  assign pkt_done  = hs & sel_last;
  // CMD keeps priority until its burst quota is spent, but never blocks an idle PIX side
  assign pick_cmd  = cmd_valid & ((burst_q < BURST_MAX) | ~pix_valid);
  assign grant     = grant_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      grant_q <= GNT_NONE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: if (cmd_valid || pix_valid) begin
        state_d = XFER;
        grant_d = pick_cmd ? GNT_CMD : GNT_PIX;
      end
      XFER: if (hs) begin
        if (GAP_CYCLES != 16'd0) state_d = GAP;
        else if (sel_last) begin
          state_d = IDLE;
          grant_d = GNT_NONE;
        end
      end
      GAP: if (gap_q <= 16'd1) begin
        if (last_q) begin
          state_d = IDLE;
          grant_d = GNT_NONE;
        end else state_d = XFER;
      end
      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  always_comb begin
    wr_valid  = (state_q == XFER) & sel_valid;
    wr_data   = wr_valid ? sel_data : 9'd0;
    cmd_ready = (state_q == XFER) & sel_cmd & wr_ready;
    pix_ready = (state_q == XFER) & (grant_q == GNT_PIX) & wr_ready;
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      last_q  <= 1'b0;
      gap_q   <= 16'd0;
      burst_q <= 4'd0;
    end else begin
      if (hs) begin
        last_q <= sel_last;
        gap_q  <= GAP_CYCLES;
      end else if (state_q == GAP) begin
        gap_q <= gap_q - 16'd1;
      end
      if (pkt_done) begin
        if (sel_cmd && pix_valid)
          burst_q <= (burst_q >= BURST_MAX) ? BURST_MAX : burst_q + 4'd1;
        else
          burst_q <= 4'd0;
      end
    end
  end

`ifdef LCD_ARB_STAT_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cmd_pkt_cnt <= 16'd0;
      pix_pkt_cnt <= 16'd0;
    end else if (stat_clr) begin
      cmd_pkt_cnt <= 16'd0;
      pix_pkt_cnt <= 16'd0;
    end else if (pkt_done) begin
      if (sel_cmd && cmd_pkt_cnt != 16'hFFFF) cmd_pkt_cnt <= cmd_pkt_cnt + 16'd1;
      if (!sel_cmd && pix_pkt_cnt != 16'hFFFF) pix_pkt_cnt <= pix_pkt_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// Directed bench for lcd_spi_arbiter: queue-driven requesters plus a packet-level
// reference model checked every cycle, with literal expectations per scenario.
module tb_lcd_spi_arbiter;
  localparam int GAP  = 3;
  localparam int MAXB = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid, cmd_last, cmd_ready, pix_valid, pix_last, pix_ready;
  logic [8:0] cmd_data, pix_data, wr_data;
  logic wr_valid, wr_ready, busy;
  logic [1:0] grant;
`ifdef LCD_ARB_STAT_EN
  logic stat_clr;
  logic [15:0] cmd_pkt_cnt, pix_pkt_cnt;
`endif

  lcd_spi_arbiter #(.GAP_CYCLES(16'(GAP)), .MAX_CMD_BURST(MAXB)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_last(cmd_last), .cmd_ready(cmd_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last), .pix_ready(pix_ready),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .grant(grant), .busy(busy)
`ifdef LCD_ARB_STAT_EN
    , .stat_clr(stat_clr), .cmd_pkt_cnt(cmd_pkt_cnt), .pix_pkt_cnt(pix_pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // requester stimulus queues ({last, word}) and their expected-order copies
  logic [9:0] cmd_q[$], pix_q[$], exp_cmd[$], exp_pix[$];
  bit pix_hold = 0;
  int pix_sent = 0;

  task automatic push(input bit is_pix, input logic [8:0] w, input bit l);
    if (is_pix) begin pix_q.push_back({l, w}); exp_pix.push_back({l, w}); end
    else        begin cmd_q.push_back({l, w}); exp_cmd.push_back({l, w}); end
  endtask

  initial begin
    bit hs_c;
    cmd_valid = 0; cmd_data = 0; cmd_last = 0;
    forever begin
      @(negedge clk); hs_c = cmd_valid && cmd_ready;
      @(posedge clk); #1;
      if (hs_c && cmd_q.size() > 0) cmd_q.delete(0);
      if (cmd_q.size() > 0) begin {cmd_last, cmd_data} = cmd_q[0]; cmd_valid = 1; end
      else begin cmd_valid = 0; cmd_last = 0; cmd_data = 0; end
    end
  end

  initial begin
    bit hs_p;
    pix_valid = 0; pix_data = 0; pix_last = 0;
    forever begin
      @(negedge clk); hs_p = pix_valid && pix_ready;
      @(posedge clk); #1;
      if (hs_p && pix_q.size() > 0) begin pix_q.delete(0); pix_sent++; end
      if (pix_q.size() > 0 && !pix_hold) begin {pix_last, pix_data} = pix_q[0]; pix_valid = 1; end
      else begin pix_valid = 0; pix_last = 0; pix_data = 0; end
    end
  end

  // packet-level reference: who should own the writer, which word comes next, spacing
  logic [1:0] m_grant = 0;
  bit m_in = 0;
  int m_burst = 0, last_hs = -100, m_cmd_pkts = 0, m_pix_pkts = 0;
  int pkt_log[$], hs_cyc[$];

  always @(negedge clk) begin
    logic [9:0] w;
    if (!rst_n) begin
      m_in = 0; m_burst = 0; last_hs = -100; m_cmd_pkts = 0; m_pix_pkts = 0;
    end else begin
      if (!wr_valid) chk("data_zero_when_idle", wr_data, 0);
      chk("ready_exclusive", cmd_ready && pix_ready, 0);
      if (!busy) chk("idle_outputs", {grant, wr_valid, cmd_ready, pix_ready}, 0);
      if (m_in) chk("grant_hold", grant, m_grant);
      if (wr_valid && wr_ready) begin
        if (!m_in) begin
          m_grant = (cmd_valid && m_burst < MAXB) ? 2'b01 : (pix_valid ? 2'b10 : 2'b01);
          m_in = 1;
        end
        chk("hs_grant", grant, m_grant);
        chk("hs_spacing_ok", (cyc - last_hs) >= GAP + 1, 1);
        last_hs = cyc;
        hs_cyc.push_back(cyc);
        if ((m_grant == 2'b01 && exp_cmd.size() == 0) || (m_grant == 2'b10 && exp_pix.size() == 0)) begin
          checks++; errors++;
          $display("FAIL unexpected_word actual=%0h required=none", wr_data);
          m_in = 0;
        end else begin
          if (m_grant == 2'b01) begin w = exp_cmd[0]; exp_cmd.delete(0); end
          else begin w = exp_pix[0]; exp_pix.delete(0); end
          chk("hs_data", wr_data, w[8:0]);
          if (w[9]) begin
            m_in = 0;
            pkt_log.push_back(m_grant == 2'b01 ? 1 : 2);
            if (m_grant == 2'b01) begin
              m_cmd_pkts++;
              m_burst = pix_valid ? ((m_burst >= MAXB) ? MAXB : m_burst + 1) : 0;
            end else begin
              m_pix_pkts++;
              m_burst = 0;
            end
          end
        end
      end
    end
  end

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cmd_q.size() == 0 && pix_q.size() == 0 && exp_cmd.size() == 0 &&
          exp_pix.size() == 0 && !busy) return;
    end
    checks++; errors++;
    $display("FAIL %s_timeout actual=busy required=idle", name);
  endtask

  task automatic wait_pix_sent(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pix_sent >= target) return;
    end
    checks++; errors++;
    $display("FAIL pix_progress_timeout actual=%0d required=%0d", pix_sent, target);
  endtask

  initial begin
    int b, ok;
    wr_ready = 1;
`ifdef LCD_ARB_STAT_EN
    stat_clr = 0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr", {wr_valid, wr_data}, 0);
    chk("rst_ready", {cmd_ready, pix_ready}, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // five-word command packet, continuous wr_ready: one word every GAP+1 cycles
    b = hs_cyc.size();
    push(0, 9'h02A, 0); push(0, 9'h100, 0); push(0, 9'h100, 0);
    push(0, 9'h100, 0); push(0, 9'h183, 1);
    wait_idle("t1", 200);
    chk("t1_word_count", hs_cyc.size() - b, 5);
    if (hs_cyc.size() - b == 5)
      for (int i = 1; i < 5; i++) chk("t1_spacing", hs_cyc[b+i] - hs_cyc[b+i-1], 4);

    // simultaneous requests: whole CMD packet first, then PIX
    b = pkt_log.size();
    push(0, 9'h011, 0); push(0, 9'h022, 0); push(0, 9'h033, 1);
    push(1, 9'h1AA, 0); push(1, 9'h1BB, 1);
    wait_idle("t2", 300);
    chk("t2_pkts", pkt_log.size() - b, 2);
    if (pkt_log.size() - b == 2) begin
      chk("t2_first", pkt_log[b], 1);
      chk("t2_second", pkt_log[b+1], 2);
    end

    // burst limit 2 with PIX pending: CMD,CMD,PIX,CMD,CMD
    b = pkt_log.size();
    push(1, 9'h1F0, 0); push(1, 9'h1F1, 1);
    for (int p = 0; p < 4; p++) begin
      push(0, 9'(9'h0A0 + 2*p), 0); push(0, 9'(9'h0A1 + 2*p), 1);
    end
    wait_idle("t3", 600);
    chk("t3_pkts", pkt_log.size() - b, 5);
    if (pkt_log.size() - b == 5) begin
      ok = (pkt_log[b] == 1 && pkt_log[b+1] == 1 && pkt_log[b+2] == 2 &&
            pkt_log[b+3] == 1 && pkt_log[b+4] == 1);
      chk("t3_order", ok, 1);
    end

    // serializer stall: word held, no gap until accepted
    wr_ready = 0;
    push(0, 9'h105, 1);
    for (int i = 0; i < 20 && !wr_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("t4_stall_word", {wr_valid, wr_data}, {1'b1, 9'h105});
      chk("t4_stall_ready", cmd_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 wr_ready = 1;
    @(negedge clk); chk("t4_accept_ready", cmd_ready, 1);
    @(negedge clk); chk("t4_gap_started", {busy, wr_valid}, 2'b10);
    repeat (3) @(negedge clk);
    chk("t4_back_idle", {busy, grant}, 0);

    // PIX stalls mid-packet while CMD waits: grant must not move
    b = pkt_log.size();
    push(1, 9'h1C0, 0); push(1, 9'h1C1, 0); push(1, 9'h1C2, 0); push(1, 9'h1C3, 1);
    ok = pix_sent;
    wait_pix_sent(ok + 2, 100);
    pix_hold = 1;
    push(0, 9'h02C, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t5_grant_pix", grant, 2'b10);
      chk("t5_cmd_blocked", cmd_ready, 0);
    end
    pix_hold = 0;
    wait_idle("t5", 300);
    chk("t5_pkts", pkt_log.size() - b, 2);
    if (pkt_log.size() - b == 2) chk("t5_order", {pkt_log[b][1:0], pkt_log[b+1][1:0]}, 4'b1001);

`ifdef LCD_ARB_STAT_EN
    chk("stat_cmd", cmd_pkt_cnt, m_cmd_pkts);
    chk("stat_pix", pix_pkt_cnt, m_pix_pkts);
`endif

    // asynchronous reset mid PIX packet
    push(1, 9'h1D0, 0); push(1, 9'h1D1, 0); push(1, 9'h1D2, 1);
    ok = pix_sent;
    wait_pix_sent(ok + 1, 100);
    #2 rst_n = 0;
    #1;
    chk("t6_async_wr_valid", wr_valid, 0);
    chk("t6_async_grant", grant, 0);
    chk("t6_async_busy", busy, 0);
    cmd_q.delete(); pix_q.delete(); exp_cmd.delete(); exp_pix.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("t6_after_busy", busy, 0);
`ifdef LCD_ARB_STAT_EN
    chk("t6_pix_cnt_cleared", pix_pkt_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
